// File: rtl/hc_sr04_emulator.sv
// hc_sr04_emulator
// Bus-mapped stand-in for an HC-SR04 ultrasonic ranger. It watches the
// trigger pulse from the ranging peripheral and answers with an echo pulse.
// The width of that pulse encodes a distance in cm that the CPU programs.
//
// Ports
//   clk      system clock
//   rst      asynchronous reset, active low
//   cs       peripheral select
//   addr     register address (5 bits)
//   rd, wr   read / write strobes, qualified by cs
//   d_in     write data (32 bits)
//   d_out    registered read data, valid one clock after cs&rd
//   trigger  trigger input from the measuring peripheral (asynchronous)
//   echo     emulated echo pulse
//
// Register map
//   0x01 DIST    [15:0] distance in cm, RW
//   0x02 STATUS  [0] busy, [1] trig_err (sticky), [31:16] echo_cnt, RO
//   0x03 CTRL    [0] enable RW, [1] write-1 clears trig_err/echo_cnt
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a synchronised trigger rising level
// TRIG    | measuring trigger high time in clocks
// BURST   | emulated 8x40 kHz burst delay before echo rises
// ECHO    | echo held high for the latched width
// HOLDOFF | dead time after echo; trigger must be low to leave
module hc_sr04_emulator #(
  parameter int CLK_FREQ       = 50000000,
  parameter int US_DIV         = CLK_FREQ / 1000000,
  parameter int TRIG_MIN_US    = 10,
  parameter int BURST_DELAY_US = 200,
  parameter int US_PER_CM      = 58,
  parameter int MAX_CM         = 400,
  parameter int TIMEOUT_US     = 38000,
  parameter int HOLDOFF_US     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  input  logic        trigger,
  output logic        echo
);

  localparam logic [4:0] ADDR_DIST   = 5'h01;
  localparam logic [4:0] ADDR_STATUS = 5'h02;
  localparam logic [4:0] ADDR_CTRL   = 5'h03;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIG    = 3'd1;
  localparam logic [2:0] S_BURST   = 3'd2;
  localparam logic [2:0] S_ECHO    = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;

  localparam logic [31:0] TRIG_MIN_CLK = 32'(TRIG_MIN_US * US_DIV);
  localparam logic [31:0] BURST_CLK    = 32'(BURST_DELAY_US * US_DIV);
  localparam logic [31:0] CM_CLK       = 32'(US_PER_CM * US_DIV);
  localparam logic [31:0] TIMEOUT_CLK  = 32'(TIMEOUT_US * US_DIV);
  localparam logic [31:0] HOLDOFF_CLK  = 32'(HOLDOFF_US * US_DIV);
  localparam logic [15:0] MAX_CM_L     = 16'(MAX_CM);

  logic        trig_meta;
  logic        trig_s;
  logic [15:0] dist_r;
  logic        enable_r;
  logic        trig_err;
  logic [15:0] echo_cnt;
  logic [2:0]  state;
  logic [31:0] cnt;
  logic        echo_r;

  logic        wr_dist;
  logic        wr_ctrl;
  logic        clr;
  logic        echo_done;
  logic        trig_short;
  logic        in_range;
  logic [31:0] echo_width;
  logic [31:0] rd_data;

  assign echo = echo_r;

  // --------------------------------------------------------------------
  // Trigger synchroniser
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
    end else begin
      trig_meta <= trigger;
      trig_s    <= trig_meta;
    end
  end

  // --------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------
  assign wr_dist = cs && wr && (addr == ADDR_DIST);
  assign wr_ctrl = cs && wr && (addr == ADDR_CTRL);
  assign clr     = wr_ctrl && d_in[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dist_r   <= 16'd0;
      enable_r <= 1'b1;
    end else begin
      if (wr_dist) dist_r <= d_in[15:0];
      if (wr_ctrl) enable_r <= d_in[0];
    end
  end

  // The FSM only produces events while enabled, so disabling freezes the
  // error flag and the pulse counter.
  assign echo_done  = enable_r && (state == S_ECHO) && (cnt == 32'd0);
  assign trig_short = enable_r && (state == S_TRIG) && !trig_s &&
                      (cnt < TRIG_MIN_CLK);

  // A new short trigger is kept even if a clear arrives in the same cycle,
  // so the error is not lost. For the pulse counter, the clear takes
  // priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_err <= 1'b0;
      echo_cnt <= 16'd0;
    end else begin
      if (trig_short) trig_err <= 1'b1;
      else if (clr)   trig_err <= 1'b0;

      if (clr)            echo_cnt <= 16'd0;
      else if (echo_done) echo_cnt <= echo_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (addr)
      ADDR_DIST:   rd_data = {16'd0, dist_r};
      ADDR_STATUS: rd_data = {echo_cnt, 14'd0, trig_err, (state != S_IDLE)};
      ADDR_CTRL:   rd_data = {31'd0, enable_r};
      default:     rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= 32'd0;
    end else if (cs && rd) begin
      d_out <= rd_data;
    end
  end

  // --------------------------------------------------------------------
  // Echo width, sampled from the DIST register value present at the latch
  // edge. A DIST write on that same edge does not affect the current pulse.
  // --------------------------------------------------------------------
  assign in_range   = (dist_r != 16'd0) && (dist_r <= MAX_CM_L);
  assign echo_width = in_range ? (32'(dist_r) * CM_CLK) : TIMEOUT_CLK;

  // --------------------------------------------------------------------
  // Sequencing FSM. cnt counts up in TRIG (high time) and down elsewhere.
  // Reload values are one less than the duration where the expiry edge
  // itself is part of the interval.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= 32'd0;
      echo_r <= 1'b0;
    end else if (!enable_r) begin
      state  <= S_IDLE;
      cnt    <= 32'd0;
      echo_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trig_s) begin
            state <= S_TRIG;
            cnt   <= 32'd1;
          end
        end
        S_TRIG: begin
          if (trig_s) begin
            if (cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
          end else if (cnt >= TRIG_MIN_CLK) begin
            state <= S_BURST;
            cnt   <= BURST_CLK;
          end else begin
            state <= S_IDLE;
            cnt   <= 32'd0;
          end
        end
        S_BURST: begin
          if (cnt == 32'd0) begin
            echo_r <= 1'b1;
            cnt    <= echo_width - 32'd1;
            state  <= S_ECHO;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_ECHO: begin
          if (cnt == 32'd0) begin
            echo_r <= 1'b0;
            cnt    <= HOLDOFF_CLK - 32'd1;
            state  <= S_HOLDOFF;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_HOLDOFF: begin
          // A trigger still high at expiry keeps the FSM here until it
          // falls. This forces a fresh rising edge before the next trigger
          // is accepted.
          if (cnt != 32'd0) begin
            cnt <= cnt - 32'd1;
          end else if (!trig_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= 32'd0;
          echo_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc_sr04_emulator.sv
module tb_hc_sr04_emulator;

  // 1 MHz clock gives one clock per microsecond. The no-object width is
  // shortened to 3800 clocks to keep the run short.
  localparam int BURST   = 200;
  localparam int HOLDOFF = 1000;
  localparam int TMO     = 3800;
  localparam int CM_CLK  = 58;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] d_in = 32'd0;
  logic        cs = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] d_out;
  logic        trigger = 1'b0;
  logic        echo;

  int checks = 0;
  int errors = 0;

  hc_sr04_emulator #(
    .CLK_FREQ(1000000),
    .US_DIV(1),
    .TIMEOUT_US(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .d_in(d_in),
    .cs(cs),
    .addr(addr),
    .rd(rd),
    .wr(wr),
    .d_out(d_out),
    .trigger(trigger),
    .echo(echo)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = d_out;
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(name, v, exp);
  endtask

  task automatic pulse(input int n);
    trigger = 1'b1;
    repeat (n) @(negedge clk);
    trigger = 1'b0;
  endtask

  // Clocks from the first edge that samples trigger low to echo rising.
  task automatic measure_lat(output int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (echo !== 1'b1 && n < 1000);
    lat = n - 1;
  endtask

  task automatic measure_width(output int w);
    w = 0;
    while (echo === 1'b1 && w < 50000) begin
      w++;
      @(negedge clk);
    end
  endtask

  task automatic watch(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (echo !== 1'b0) highs++;
    end
  endtask

  int lat, w, highs;

  initial begin
    vecs[0]  = '{1'b0, 5'h02, 32'h0,         32'h0000_0000, "rst_status"};
    vecs[1]  = '{1'b0, 5'h03, 32'h0,         32'h0000_0001, "rst_ctrl"};
    vecs[2]  = '{1'b0, 5'h01, 32'h0,         32'h0000_0000, "rst_dist"};
    vecs[3]  = '{1'b1, 5'h01, 32'hABCD_1234, 32'h0,         "wr_dist"};
    vecs[4]  = '{1'b0, 5'h01, 32'h0,         32'h0000_1234, "dist_upper0"};
    vecs[5]  = '{1'b0, 5'h00, 32'h0,         32'h0000_0000, "unmapped_00"};
    vecs[6]  = '{1'b0, 5'h1F, 32'h0,         32'h0000_0000, "unmapped_1f"};
    vecs[7]  = '{1'b1, 5'h05, 32'hFFFF_FFFF, 32'h0,         "wr_unmapped"};
    vecs[8]  = '{1'b0, 5'h01, 32'h0,         32'h0000_1234, "dist_kept"};
    vecs[9]  = '{1'b1, 5'h03, 32'h0,         32'h0,         "wr_ctrl0"};
    vecs[10] = '{1'b0, 5'h03, 32'h0,         32'h0000_0000, "ctrl_dis"};
    vecs[11] = '{1'b1, 5'h03, 32'h3,         32'h0,         "wr_ctrl3"};
    vecs[12] = '{1'b0, 5'h03, 32'h0,         32'h0000_0001, "ctrl_bit1_reads0"};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_echo", {31'd0, echo}, 32'd0);
    check("rst_dout", d_out, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_wr) bus_write(vecs[i].a, vecs[i].d);
      else read_check(vecs[i].name, vecs[i].a, vecs[i].exp);
    end

    // Basic ranging: 10 cm
    bus_write(5'h01, 32'd10);
    pulse(12);
    measure_lat(lat);
    check("basic_lat", 32'(lat), 32'(BURST + 3));
    measure_width(w);
    check("basic_width", 32'(w), 32'(10 * CM_CLK));
    repeat (HOLDOFF + 10) @(negedge clk);
    read_check("basic_status", 5'h02, 32'h0001_0000);

    // Short trigger
    pulse(5);
    watch(2000, highs);
    check("short_no_echo", 32'(highs), 32'd0);
    read_check("short_status", 5'h02, 32'h0001_0002);
    bus_write(5'h03, 32'h3);
    read_check("clear_status", 5'h02, 32'h0000_0000);

    // Minimum valid trigger: exactly 10 clocks
    bus_write(5'h01, 32'd400);
    pulse(10);
    measure_lat(lat);
    check("min_trig_lat", 32'(lat), 32'(BURST + 3));
    measure_width(w);
    check("max_cm_width", 32'(w), 32'(400 * CM_CLK));
    repeat (HOLDOFF + 10) @(negedge clk);

    // Out of range distances
    bus_write(5'h01, 32'd0);
    pulse(12);
    measure_lat(lat);
    check("oor0_lat", 32'(lat), 32'(BURST + 3));
    measure_width(w);
    check("oor0_width", 32'(w), 32'(TMO));
    repeat (HOLDOFF + 10) @(negedge clk);
    bus_write(5'h01, 32'd500);
    pulse(12);
    measure_lat(lat);
    measure_width(w);
    check("oor500_width", 32'(w), 32'(TMO));
    repeat (HOLDOFF + 10) @(negedge clk);
    read_check("oor_status", 5'h02, 32'h0003_0000);
    bus_write(5'h03, 32'h3);

    // Holdoff and retrigger
    bus_write(5'h01, 32'd10);
    pulse(12);
    measure_lat(lat);
    measure_width(w);
    check("ho_width1", 32'(w), 32'(10 * CM_CLK));
    repeat (100) @(negedge clk);
    pulse(12);
    watch(1200, highs);
    check("ho_ignored", 32'(highs), 32'd0);
    read_check("ho_status1", 5'h02, 32'h0001_0000);
    pulse(12);
    measure_lat(lat);
    check("ho_lat2", 32'(lat), 32'(BURST + 3));
    measure_width(w);
    check("ho_width2", 32'(w), 32'(10 * CM_CLK));
    trigger = 1'b1;
    repeat (HOLDOFF + 100) @(negedge clk);
    trigger = 1'b0;
    watch(400, highs);
    check("ho_held_trig", 32'(highs), 32'd0);
    read_check("ho_status2", 5'h02, 32'h0002_0000);

    // Disable during echo
    bus_write(5'h01, 32'd100);
    pulse(12);
    measure_lat(lat);
    check("dis_lat", 32'(lat), 32'(BURST + 3));
    repeat (50) @(negedge clk);
    bus_write(5'h03, 32'h0);
    @(negedge clk);
    check("dis_echo_low", {31'd0, echo}, 32'd0);
    read_check("dis_status", 5'h02, 32'h0002_0000);
    pulse(12);
    watch(500, highs);
    check("dis_no_echo", 32'(highs), 32'd0);
    read_check("dis_status2", 5'h02, 32'h0002_0000);
    bus_write(5'h03, 32'h1);

    // Reset mid-echo
    bus_write(5'h01, 32'd20);
    pulse(12);
    measure_lat(lat);
    repeat (10) @(negedge clk);
    check("pre_rst_echo", {31'd0, echo}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_echo_async", {31'd0, echo}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    read_check("rst2_status", 5'h02, 32'h0000_0000);
    read_check("rst2_ctrl", 5'h03, 32'h0000_0001);
    read_check("rst2_dist", 5'h01, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
